// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle control sequencer for a MIPS-subset datapath (lw, sw, j, jr,
// jal, bne, xori, addi, add, sub, slt). It latches the fetched opcode/funct
// and steps the shared PC adder, ALU, register file and data memory through
// FETCH/DECODE/EXEC/MEM/WB. Data memory uses a req/ready handshake, so MEM
// may be stretched by wait states. Unsupported encodings park the machine in
// HALT until rst_n is asserted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   instr             instruction-memory output, sampled in FETCH
//   zero              ALU zero flag, used in EXEC for bne
//   mem_ready         data memory completes the access this cycle (MEM only)
//   ir_wr             instruction latch enable
//   pc_wr, pc_sel     PC load strobe and source (00 jump, 01 rs, 10 adder)
//   adder_imm         adder operand A = sign-extended immediate
//   adder_8           adder operand B = 8 instead of 4
//   reg_wr_en         register-file write strobe
//   reg_data_sel      00 ALU, 01 memory, 11 adder
//   reg_addr_sel      00 rd, 01 rt, 11 r31
//   alu_imm, alu_cmd  ALU operand B select, ALU command (0 add,1 sub,2 xor,3 slt)
//   mem_req,mem_wr_en data-memory request and write qualifier
//   state             current state encoding
//   halted            sticky illegal-instruction flag
//   retired           instructions completed since reset (wraps)
module multicycle_control #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               ir_wr,
    output logic               pc_wr,
    output logic [1:0]         pc_sel,
    output logic               adder_imm,
    output logic               adder_8,
    output logic               reg_wr_en,
    output logic [1:0]         reg_data_sel,
    output logic [1:0]         reg_addr_sel,
    output logic               alu_imm,
    output logic [2:0]         alu_cmd,
    output logic               mem_req,
    output logic               mem_wr_en,
    output logic [2:0]         state,
    output logic               halted,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    state_t             state_r;
    logic [5:0]         opcode_r;
    logic [5:0]         funct_r;
    logic               halted_r;
    logic [COUNT_W-1:0] retired_r;

    logic is_j_s, is_jr_s, is_jal_s, is_bne_s, is_addi_s, is_xori_s;
    logic is_lw_s, is_sw_s, is_add_s, is_sub_s, is_slt_s, legal_s;

    // Ungated control values; the port values are forced to 0 while rst_n is low.
    logic       ir_wr_s, pc_wr_s, adder_imm_s, adder_8_s, reg_wr_en_s;
    logic       alu_imm_s, mem_req_s, mem_wr_en_s;
    logic [1:0] pc_sel_s, reg_data_sel_s, reg_addr_sel_s;
    logic [2:0] alu_cmd_s;

    // Instruction class decode from the latched opcode/funct fields.
    always_comb begin
        is_j_s    = (opcode_r == OP_J);
        is_jal_s  = (opcode_r == OP_JAL);
        is_bne_s  = (opcode_r == OP_BNE);
        is_addi_s = (opcode_r == OP_ADDI);
        is_xori_s = (opcode_r == OP_XORI);
        is_lw_s   = (opcode_r == OP_LW);
        is_sw_s   = (opcode_r == OP_SW);
        is_jr_s   = (opcode_r == OP_RTYPE) && (funct_r == FN_JR);
        is_add_s  = (opcode_r == OP_RTYPE) && (funct_r == FN_ADD);
        is_sub_s  = (opcode_r == OP_RTYPE) && (funct_r == FN_SUB);
        is_slt_s  = (opcode_r == OP_RTYPE) && (funct_r == FN_SLT);
        legal_s   = is_j_s | is_jal_s | is_bne_s | is_addi_s | is_xori_s |
                    is_lw_s | is_sw_s | is_jr_s | is_add_s | is_sub_s | is_slt_s;
    end

    // Per-state control decode; anything not driven in a state stays 0.
    always_comb begin
        ir_wr_s        = 1'b0;
        pc_wr_s        = 1'b0;
        pc_sel_s       = 2'b00;
        adder_imm_s    = 1'b0;
        adder_8_s      = 1'b0;
        reg_wr_en_s    = 1'b0;
        reg_data_sel_s = 2'b00;
        reg_addr_sel_s = 2'b00;
        alu_imm_s      = 1'b0;
        alu_cmd_s      = 3'd0;
        mem_req_s      = 1'b0;
        mem_wr_en_s    = 1'b0;
        case (state_r)
            ST_FETCH: ir_wr_s = 1'b1;
            ST_DECODE: begin
                if (is_jr_s) begin
                    pc_sel_s = 2'b01;
                    pc_wr_s  = 1'b1;
                end else if (is_j_s || is_jal_s) begin
                    pc_sel_s       = 2'b00;
                    pc_wr_s        = 1'b1;
                    reg_wr_en_s    = is_jal_s;
                    reg_data_sel_s = is_jal_s ? 2'b11 : 2'b00;
                    reg_addr_sel_s = is_jal_s ? 2'b11 : 2'b00;
                    adder_8_s      = is_jal_s;
                end else begin
                    pc_wr_s = 1'b0;
                end
            end
            ST_EXEC: begin
                alu_imm_s = is_lw_s | is_sw_s | is_addi_s | is_xori_s;
                if (is_xori_s) begin
                    alu_cmd_s = 3'd2;
                end else if (is_sub_s || is_bne_s) begin
                    alu_cmd_s = 3'd1;
                end else if (is_slt_s) begin
                    alu_cmd_s = 3'd3;
                end else begin
                    alu_cmd_s = 3'd0;
                end
                // The branch decision is taken in EXEC: the adder picks the
                // offset only when the compared registers differ.
                if (is_bne_s) begin
                    pc_sel_s    = 2'b10;
                    pc_wr_s     = 1'b1;
                    adder_imm_s = ~zero;
                end else begin
                    pc_wr_s = 1'b0;
                end
            end
            ST_MEM: begin
                mem_req_s   = 1'b1;
                mem_wr_en_s = is_sw_s;
                // A store retires in the cycle its access completes.
                if (mem_ready && is_sw_s) begin
                    pc_sel_s = 2'b10;
                    pc_wr_s  = 1'b1;
                end else begin
                    pc_wr_s = 1'b0;
                end
            end
            ST_WB: begin
                reg_wr_en_s    = 1'b1;
                pc_sel_s       = 2'b10;
                pc_wr_s        = 1'b1;
                reg_data_sel_s = is_lw_s ? 2'b01 : 2'b00;
                reg_addr_sel_s = (is_lw_s || is_addi_s || is_xori_s) ? 2'b01 : 2'b00;
            end
            default: ir_wr_s = 1'b0;
        endcase
    end

    // Sequencer state, latched instruction fields, halt flag and retire count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_FETCH;
            opcode_r  <= 6'd0;
            funct_r   <= 6'd0;
            halted_r  <= 1'b0;
            retired_r <= {COUNT_W{1'b0}};
        end else begin
            if (pc_wr_s) begin
                retired_r <= retired_r + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
            case (state_r)
                ST_FETCH: begin
                    opcode_r <= instr[31:26];
                    funct_r  <= instr[5:0];
                    state_r  <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (is_j_s || is_jr_s || is_jal_s) begin
                        state_r <= ST_FETCH;
                    end else if (!legal_s) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_lw_s || is_sw_s) begin
                        state_r <= ST_MEM;
                    end else if (is_bne_s) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state_r <= is_lw_s ? ST_WB : ST_FETCH;
                    end else begin
                        state_r <= ST_MEM;
                    end
                end
                ST_WB:   state_r <= ST_FETCH;
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_FETCH;
            endcase
        end
    end

    // Reset forces every output low without waiting for a clock edge.
    assign ir_wr        = ir_wr_s & rst_n;
    assign pc_wr        = pc_wr_s & rst_n;
    assign pc_sel       = pc_sel_s & {2{rst_n}};
    assign adder_imm    = adder_imm_s & rst_n;
    assign adder_8      = adder_8_s & rst_n;
    assign reg_wr_en    = reg_wr_en_s & rst_n;
    assign reg_data_sel = reg_data_sel_s & {2{rst_n}};
    assign reg_addr_sel = reg_addr_sel_s & {2{rst_n}};
    assign alu_imm      = alu_imm_s & rst_n;
    assign alu_cmd      = alu_cmd_s & {3{rst_n}};
    assign mem_req      = mem_req_s & rst_n;
    assign mem_wr_en    = mem_wr_en_s & rst_n;
    assign state        = state_r;
    assign halted       = halted_r;
    assign retired      = retired_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, in the middle of the cycle.
module tb_multicycle_control;

    localparam logic [31:0] I_ADD  = 32'h00221820;  // add  $3,$1,$2
    localparam logic [31:0] I_LW   = 32'h8C220004;  // lw   $2,4($1)
    localparam logic [31:0] I_SW   = 32'hAC220008;  // sw   $2,8($1)
    localparam logic [31:0] I_BNE  = 32'h14220010;  // bne  $1,$2,0x10
    localparam logic [31:0] I_JAL  = 32'h0C000010;  // jal  0x10
    localparam logic [31:0] I_JR   = 32'h03E00008;  // jr   $31
    localparam logic [31:0] I_XORI = 32'h38220005;  // xori $2,$1,5
    localparam logic [31:0] I_BAD  = 32'hFC000000;  // opcode 0x3F

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        ir_wr, pc_wr, adder_imm, adder_8, reg_wr_en, alu_imm;
    logic        mem_req, mem_wr_en, halted;
    logic [1:0]  pc_sel, reg_data_sel, reg_addr_sel;
    logic [2:0]  alu_cmd, state;
    logic [31:0] retired;

    int n_checks = 0;
    int n_errors = 0;
    int exp_retired = 0;

    multicycle_control #(.COUNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_sel(pc_sel), .adder_imm(adder_imm),
        .adder_8(adder_8), .reg_wr_en(reg_wr_en), .reg_data_sel(reg_data_sel),
        .reg_addr_sel(reg_addr_sel), .alu_imm(alu_imm), .alu_cmd(alu_cmd),
        .mem_req(mem_req), .mem_wr_en(mem_wr_en), .state(state), .halted(halted),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Advance to the middle of the next cycle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr = I_ADD; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (ir_wr !== 1'b0) begin n_errors++; $display("FAIL rst_ir_wr: got %0b want 0", ir_wr); end
        n_checks++; if (pc_wr !== 1'b0) begin n_errors++; $display("FAIL rst_pc_wr: got %0b want 0", pc_wr); end
        n_checks++; if (state !== 3'd0) begin n_errors++; $display("FAIL rst_state: got %0d want 0", state); end
        n_checks++; if (retired !== 32'd0) begin n_errors++; $display("FAIL rst_retired: got %0d want 0", retired); end
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL rst_halted: got %0b want 0", halted); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_retired = 0;
        n_checks++; if (ir_wr !== 1'b1 || state !== 3'd0) begin n_errors++; $display("FAIL first_fetch: ir_wr=%0b state=%0d want 1/0", ir_wr, state); end
    endtask

    task automatic test_add();
        instr = I_ADD; mem_ready = 1'b1;
        #1;
        n_checks++; if (pc_wr !== 1'b0 || reg_wr_en !== 1'b0) begin n_errors++; $display("FAIL add_fetch_strobes: pc_wr=%0b reg_wr_en=%0b want 0/0", pc_wr, reg_wr_en); end
        tick();
        n_checks++; if (state !== 3'd1 || ir_wr !== 1'b0) begin n_errors++; $display("FAIL add_decode: state=%0d ir_wr=%0b want 1/0", state, ir_wr); end
        tick();
        n_checks++; if (state !== 3'd2 || alu_cmd !== 3'd0 || alu_imm !== 1'b0 || mem_req !== 1'b0) begin n_errors++; $display("FAIL add_exec: state=%0d cmd=%0d imm=%0b req=%0b want 2/0/0/0", state, alu_cmd, alu_imm, mem_req); end
        tick();
        n_checks++; if (state !== 3'd4 || reg_wr_en !== 1'b1 || reg_addr_sel !== 2'b00 || reg_data_sel !== 2'b00 || alu_cmd !== 3'd0 || pc_wr !== 1'b1 || pc_sel !== 2'b10) begin
            n_errors++; $display("FAIL add_wb: state=%0d we=%0b asel=%0d dsel=%0d cmd=%0d pc_wr=%0b pc_sel=%0d want 4/1/0/0/0/1/2", state, reg_wr_en, reg_addr_sel, reg_data_sel, alu_cmd, pc_wr, pc_sel); end
        exp_retired++;
        tick();
        n_checks++; if (state !== 3'd0 || retired !== exp_retired) begin n_errors++; $display("FAIL add_retire: state=%0d retired=%0d want 0/%0d", state, retired, exp_retired); end
    endtask

    task automatic test_lw_wait();
        instr = I_LW; mem_ready = 1'b1;  // ready outside MEM must be ignored
        tick(); tick();
        n_checks++; if (state !== 3'd2 || alu_cmd !== 3'd0 || alu_imm !== 1'b1) begin n_errors++; $display("FAIL lw_exec: state=%0d cmd=%0d imm=%0b want 2/0/1", state, alu_cmd, alu_imm); end
        @(negedge clk); mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = (i == 2);
            #1;
            n_checks++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_wr_en !== 1'b0 || pc_wr !== 1'b0) begin
                n_errors++; $display("FAIL lw_mem%0d: state=%0d req=%0b wr=%0b pc_wr=%0b want 3/1/0/0", i, state, mem_req, mem_wr_en, pc_wr); end
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        n_checks++; if (state !== 3'd4 || reg_data_sel !== 2'b01 || reg_addr_sel !== 2'b01 || reg_wr_en !== 1'b1 || pc_wr !== 1'b1) begin
            n_errors++; $display("FAIL lw_wb: state=%0d dsel=%0d asel=%0d we=%0b pc_wr=%0b want 4/1/1/1/1", state, reg_data_sel, reg_addr_sel, reg_wr_en, pc_wr); end
        exp_retired++;
        tick();
        n_checks++; if (state !== 3'd0 || retired !== exp_retired) begin n_errors++; $display("FAIL lw_total: state=%0d retired=%0d want 0/%0d", state, retired, exp_retired); end
    endtask

    task automatic test_bne(input logic z);
        instr = I_BNE;
        tick(); tick();
        zero = z; #1;
        n_checks++; if (state !== 3'd2 || pc_wr !== 1'b1 || pc_sel !== 2'b10 || alu_cmd !== 3'd1 || alu_imm !== 1'b0) begin
            n_errors++; $display("FAIL bne_exec_z%0b: state=%0d pc_wr=%0b pc_sel=%0d cmd=%0d imm=%0b want 2/1/2/1/0", z, state, pc_wr, pc_sel, alu_cmd, alu_imm); end
        n_checks++; if (adder_imm !== ~z) begin n_errors++; $display("FAIL bne_adder_imm_z%0b: got %0b want %0b", z, adder_imm, ~z); end
        exp_retired++;
        tick(); zero = 1'b0;
        n_checks++; if (state !== 3'd0 || retired !== exp_retired) begin n_errors++; $display("FAIL bne_total_z%0b: state=%0d retired=%0d want 0/%0d", z, state, retired, exp_retired); end
    endtask

    task automatic test_jumps();
        instr = I_JAL;
        tick();
        n_checks++; if (state !== 3'd1 || pc_sel !== 2'b00 || pc_wr !== 1'b1 || reg_addr_sel !== 2'b11 || reg_data_sel !== 2'b11 || adder_8 !== 1'b1 || reg_wr_en !== 1'b1) begin
            n_errors++; $display("FAIL jal_decode: state=%0d pc_sel=%0d pc_wr=%0b asel=%0d dsel=%0d a8=%0b we=%0b want 1/0/1/3/3/1/1", state, pc_sel, pc_wr, reg_addr_sel, reg_data_sel, adder_8, reg_wr_en); end
        exp_retired++;
        instr = I_JR;
        tick();
        n_checks++; if (state !== 3'd0 || retired !== exp_retired) begin n_errors++; $display("FAIL jal_total: state=%0d retired=%0d want 0/%0d", state, retired, exp_retired); end
        tick();
        n_checks++; if (state !== 3'd1 || pc_sel !== 2'b01 || pc_wr !== 1'b1 || reg_wr_en !== 1'b0 || adder_8 !== 1'b0) begin
            n_errors++; $display("FAIL jr_decode: state=%0d pc_sel=%0d pc_wr=%0b we=%0b a8=%0b want 1/1/1/0/0", state, pc_sel, pc_wr, reg_wr_en, adder_8); end
        exp_retired++;
        tick();
        n_checks++; if (state !== 3'd0 || retired !== exp_retired) begin n_errors++; $display("FAIL jr_total: state=%0d retired=%0d want 0/%0d", state, retired, exp_retired); end
    endtask

    task automatic test_xori();
        instr = I_XORI;
        tick(); tick();
        n_checks++; if (state !== 3'd2 || alu_cmd !== 3'd2 || alu_imm !== 1'b1) begin n_errors++; $display("FAIL xori_exec: state=%0d cmd=%0d imm=%0b want 2/2/1", state, alu_cmd, alu_imm); end
        tick();
        n_checks++; if (state !== 3'd4 || reg_addr_sel !== 2'b01 || reg_data_sel !== 2'b00 || reg_wr_en !== 1'b1) begin
            n_errors++; $display("FAIL xori_wb: state=%0d asel=%0d dsel=%0d we=%0b want 4/1/0/1", state, reg_addr_sel, reg_data_sel, reg_wr_en); end
        exp_retired++;
        tick();
        n_checks++; if (state !== 3'd0 || retired !== exp_retired) begin n_errors++; $display("FAIL xori_total: state=%0d retired=%0d want 0/%0d", state, retired, exp_retired); end
    endtask

    task automatic test_sw_no_wait();
        instr = I_SW; mem_ready = 1'b0;
        tick(); tick(); tick();
        mem_ready = 1'b1; #1;
        n_checks++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_wr_en !== 1'b1 || pc_wr !== 1'b1 || pc_sel !== 2'b10 || reg_wr_en !== 1'b0) begin
            n_errors++; $display("FAIL sw_mem: state=%0d req=%0b wr=%0b pc_wr=%0b pc_sel=%0d we=%0b want 3/1/1/1/2/0", state, mem_req, mem_wr_en, pc_wr, pc_sel, reg_wr_en); end
        exp_retired++;
        tick(); mem_ready = 1'b0;
        n_checks++; if (state !== 3'd0 || retired !== exp_retired) begin n_errors++; $display("FAIL sw_total: state=%0d retired=%0d want 0/%0d", state, retired, exp_retired); end
    endtask

    task automatic test_sw_reset();
        instr = I_SW; mem_ready = 1'b0;
        tick(); tick(); tick(); tick();
        n_checks++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_wr_en !== 1'b1 || pc_wr !== 1'b0) begin
            n_errors++; $display("FAIL swr_wait: state=%0d req=%0b wr=%0b pc_wr=%0b want 3/1/1/0", state, mem_req, mem_wr_en, pc_wr); end
        rst_n = 1'b0; #1;
        n_checks++; if (mem_req !== 1'b0 || mem_wr_en !== 1'b0 || state !== 3'd0 || retired !== 32'd0) begin
            n_errors++; $display("FAIL swr_async: req=%0b wr=%0b state=%0d retired=%0d want 0/0/0/0", mem_req, mem_wr_en, state, retired); end
        @(negedge clk); rst_n = 1'b1; instr = I_ADD; #1;
        exp_retired = 0;
        n_checks++; if (state !== 3'd0 || retired !== 32'd0 || ir_wr !== 1'b1) begin
            n_errors++; $display("FAIL swr_restart: state=%0d retired=%0d ir_wr=%0b want 0/0/1", state, retired, ir_wr); end
    endtask

    task automatic test_halt();
        instr = I_BAD;
        tick();
        instr = I_ADD;
        n_checks++; if (state !== 3'd1 || pc_wr !== 1'b0 || reg_wr_en !== 1'b0) begin n_errors++; $display("FAIL halt_decode: state=%0d pc_wr=%0b we=%0b want 1/0/0", state, pc_wr, reg_wr_en); end
        for (int i = 0; i < 12; i++) begin
            mem_ready = i[0];
            tick();
            n_checks++; if (state !== 3'd5 || halted !== 1'b1 || ir_wr !== 1'b0 || pc_wr !== 1'b0 || reg_wr_en !== 1'b0 || mem_req !== 1'b0 || retired !== exp_retired) begin
                n_errors++; $display("FAIL halt_hold%0d: state=%0d halted=%0b ir=%0b pc=%0b we=%0b req=%0b retired=%0d want 5/1/0/0/0/0/%0d", i, state, halted, ir_wr, pc_wr, reg_wr_en, mem_req, retired, exp_retired); end
        end
        mem_ready = 1'b0;
        rst_n = 1'b0; #1;
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL halt_clear: got %0b want 0", halted); end
        @(negedge clk); rst_n = 1'b1; #1;
        exp_retired = 0;
        n_checks++; if (state !== 3'd0 || ir_wr !== 1'b1 || halted !== 1'b0) begin n_errors++; $display("FAIL halt_restart: state=%0d ir_wr=%0b halted=%0b want 0/1/0", state, ir_wr, halted); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_bne(1'b0);
        test_bne(1'b1);
        test_jumps();
        test_xori();
        test_sw_no_wait();
        test_sw_reset();
        test_add();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control sequencer for the MIPS-subset datapath (lw, sw, j, jr, jal, bne, xori, addi, add, sub, slt). It replaces per-opcode single-cycle decode with a state machine. The machine latches the fetched instruction and steps the shared PC adder, ALU, regfile and data memory through FETCH/DECODE/EXEC/MEM/WB. Data-memory accesses go through a req/ready handshake so the memory may insert wait states. The block also counts retired instructions and halts on an unsupported encoding.

## Interface
- COUNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  instruction-memory output, sampled in FETCH
- zero  in  1  ALU zero flag, sampled in EXEC for bne
- mem_ready  in  1  data memory completes the current access this cycle
- ir_wr  out  1  instruction latch enable (high in FETCH)
- pc_wr  out  1  PC load strobe; exactly one cycle per instruction
- pc_sel  out  2  00 jump target {PC[31:28],addr,00}, 01 rs, 10 adder
- adder_imm  out  1  adder operand A = sign-ext imm (branch) instead of PC
- adder_8  out  1  adder operand B = 8 (link) instead of 4
- reg_wr_en  out  1  regfile write strobe
- reg_data_sel  out  2  00 ALU, 01 memory, 11 adder
- reg_addr_sel  out  2  00 rd, 01 rt, 11 r31
- alu_imm  out  1  ALU operand B = immediate
- alu_cmd  out  3  0 add, 1 sub, 2 xor, 3 slt
- mem_req  out  1  data-memory access request
- mem_wr_en  out  1  data-memory write (valid only with mem_req)
- state  out  3  current state encoding
- halted  out  1  sticky illegal-instruction flag
- retired  out  COUNT_W  instructions completed since reset

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to FETCH next cycle with all strobes 0.
- FETCH: ir_wr=1 and opcode/funct are latched from instr, then go to DECODE. All controls are decoded from the latched fields, never from instr directly.
- DECODE:
  - j: pc_sel=00, pc_wr, go to FETCH.
  - jr (op 0, funct 08): pc_sel=01, pc_wr, go to FETCH.
  - jal: pc_sel=00, pc_wr, reg_wr_en, reg_data_sel=11, reg_addr_sel=11, adder_8, go to FETCH.
  - Any other supported op goes to EXEC.
  - An unsupported op/funct goes to HALT.
- EXEC:
  - Drives alu_cmd/alu_imm: lw/sw/addi add+imm, xori xor+imm, add/sub/slt register operands, bne sub register operands.
  - lw and sw go to MEM.
  - bne: pc_sel=10, pc_wr, adder_imm=!zero, go to FETCH.
  - ALU ops go to WB.
- MEM:
  - mem_req=1, with mem_wr_en=1 for sw, held with constant controls until mem_ready.
  - On ready, lw goes to WB.
  - On ready, sw asserts pc_sel=10 and pc_wr, then goes to FETCH.
- WB: reg_wr_en=1, pc_sel=10, pc_wr, go to FETCH.
  - lw uses reg_data_sel=01 and reg_addr_sel=01.
  - I-type ALU ops use 00/01.
  - R-type ops use 00/00.
- retired increments on every pc_wr cycle and wraps at 2^COUNT_W−1 to 0.
- HALT: all strobes 0, halted=1, retired frozen. Only rst_n exits.
- Any output not named for a state is 0 in that state.

## Timing
- Reset values: state=FETCH, halted=0, retired=0, latched opcode/funct=0, every output 0 while rst_n low.
- First FETCH (ir_wr=1) occurs in the first cycle after rst_n rises.
- Cycles per instruction:
  - j/jr/jal: 2
  - bne and sw with zero wait: 3 for bne, 4 for sw
  - ALU ops: 4
  - lw with zero wait: 5
  - Each cycle mem_ready is low in MEM adds 1.
- mem_ready is ignored outside MEM. If mem_ready is high on the first MEM cycle, the access completes in that cycle.
- pc_wr, reg_wr_en and mem_wr_en are never asserted in the same cycle as ir_wr.
- rst_n asserted mid-instruction (including during a MEM wait): outputs go to 0 immediately (asynchronous). No partial register or memory write completes. Restart is at FETCH.

## Test plan
- Reset released, instr=add $3,$1,$2 (0x00221820): states 0,1,2,4. WB shows reg_wr_en=1, reg_addr_sel=00, alu_cmd=0, pc_wr=1. retired=1 after 4 cycles.
- lw $2,4($1) (0x8C220004) with mem_ready low for 2 cycles: MEM lasts 3 cycles with mem_req=1 and mem_wr_en=0. WB has reg_data_sel=01. Total 7 cycles.
- bne with zero=0: EXEC shows pc_wr=1, adder_imm=1, alu_cmd=1. Repeat with zero=1: adder_imm=0. Each instruction takes 3 cycles.
- jal 0x0000010 (0x0C000010): DECODE shows pc_sel=00, reg_addr_sel=11, reg_data_sel=11, adder_8=1, reg_wr_en=1. Back to FETCH after 2 cycles.
- Opcode 0x3F: DECODE→HALT, halted=1 and all strobes 0 for 10+ cycles, retired unchanged. rst_n pulse clears halted.
- Assert rst_n low during a sw MEM wait: mem_req and mem_wr_en drop in the same cycle. After release, state=0 and retired=0.
